// File: rtl/uart_transmit_if.sv
// uart_transmit_if: valid/ready byte handshake into the UART transmit FIFO
interface uart_transmit_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 UART transmitter fed by a small byte FIFO; LEDG mirrors the last byte launched
module uart_transmit #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_transmit_if.slave             s_if,
  output logic                       tx,
  output logic                       tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                 LEDG
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt, r_ledg;
  logic          r_tx, w_tx_nxt, w_pop, w_push, w_bit_end;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  assign s_if.tx_ready = r_count != CW'(FIFO_DEPTH);
  assign w_push        = s_if.tx_valid && s_if.tx_ready;
  assign w_bit_end     = r_baud == BW'(CLKS_PER_BIT - 1);
  assign tx            = r_tx;
  assign tx_busy       = r_state != IDLE;
  assign fifo_count    = r_count;
  assign LEDG          = r_ledg;
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_shift_nxt = r_mem[r_rptr];
        end
      end
      START: if (w_bit_end) begin
        w_state_nxt = DATA;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
      end
      DATA: if (w_bit_end) begin
        w_baud_nxt  = '0;
        w_shift_nxt = r_shift >> 1;
        w_bit_nxt   = r_bit + 1'b1;
        w_state_nxt = r_bit == 3'd7 ? STOP : DATA;
      end
      STOP: if (w_bit_end) begin
        w_baud_nxt  = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // tx is registered from the next state so it only moves on bit boundaries
    w_tx_nxt = w_state_nxt == START ? 1'b0 : w_state_nxt == DATA ? w_shift_nxt[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ledg  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_ledg <= r_mem[r_rptr];
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_if.tx_data;
  end
endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: frame-timeline model plus loopback decoder checking uart_transmit
module tb_uart_transmit;
  localparam int N = 434;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, tx_busy;
  logic [2:0] fifo_count;
  logic [7:0] LEDG;
  uart_transmit_if bus ();
  uart_transmit #(.CLKS_PER_BIT(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .s_if(bus), .tx(tx), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .LEDG(LEDG));
  always #10 clk = ~clk;
  int n_cmp = 0, n_err = 0, cyc = 0, epoch = 0, n_tog = 0;
  always @(posedge clk) cyc++;
  always @(negedge rst) epoch++;
  always @(tx) n_tog++;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask
  // Model: queue of accepted bytes and the cycle offset inside the current frame
  logic [7:0] m_q[$];
  logic [7:0] m_byte, m_led;
  bit m_active;
  int m_t;
  function automatic logic bitval(input int t, input logic [7:0] b);
    int i = t / N;
    return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_active = 0;
      m_t = 0;
      m_led = 8'h00;
      m_byte = 8'h00;
    end else begin
      bit acc;
      acc = bus.tx_valid && (m_q.size() < D);
      if (m_active) begin
        m_t++;
        if (m_t == 10 * N) m_active = 0;
      end else if (m_q.size() > 0) begin
        m_byte = m_q.pop_front();
        m_led = m_byte;
        m_active = 1;
        m_t = 0;
      end
      if (acc) m_q.push_back(bus.tx_data);
    end
  end
  always @(negedge clk) begin
    chk("tx", tx, m_active ? bitval(m_t, m_byte) : 1'b1);
    chk("tx_busy", tx_busy, m_active);
    chk("fifo_count", fifo_count, m_q.size());
    chk("tx_ready", bus.tx_ready, m_q.size() < D);
    chk("LEDG", LEDG, m_led);
  end
  // Loopback receiver: samples mid-bit, discards frames cut by reset
  logic [7:0] rx_q[$];
  int rx_t[$];
  initial begin
    logic [9:0] bits;
    int ep, t0;
    forever begin
      @(negedge tx);
      ep = epoch;
      t0 = cyc;
      for (int i = 0; i < 10; i++) begin
        repeat (i == 0 ? N / 2 : N) @(posedge clk);
        #1 bits[i] = tx;
      end
      if (ep == epoch && rst) begin
        chk("rx_start", bits[0], 0);
        chk("rx_stop", bits[9], 1);
        rx_q.push_back(bits[8:1]);
        rx_t.push_back(t0);
      end
    end
  end
  int acc_cyc;
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 bus.tx_data = b;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1 acc_cyc = cyc;
    bus.tx_valid = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    int i = 0;
    while ((tx_busy || fifo_count != 0) && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", i < lim, 1);
  endtask
  initial begin
    int t, n, nrx, acc[6];
    logic [7:0] exp_burst[6];
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    #1 rst = 1'b0;
    #100 rst = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ledg", LEDG, 8'h00);
    t = n_tog;
    repeat (500) @(negedge clk);
    chk("rst_quiet", n_tog - t, 0);
    // Single byte 0xA5
    nrx = rx_q.size();
    send(8'hA5);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tx_busy) n++;
    end
    chk("busy_len", n, 4340);
    chk("a5_ledg", LEDG, 8'hA5);
    chk("a5_rx_cnt", rx_q.size() - nrx, 1);
    if (rx_q.size() > nrx) begin
      chk("a5_rx", rx_q[$], 8'hA5);
      chk("a5_latency", rx_t[$] - acc_cyc, 1);
    end
    // Burst 0x10..0x15 with valid held, plus full-FIFO write attempts
    nrx = rx_q.size();
    @(posedge clk);
    #1 bus.tx_valid = 1'b1;
    for (int b = 0; b < 6; b++) begin
      bit r;
      int k = 0;
      bus.tx_data = 8'h10 + 8'(b);
      exp_burst[b] = 8'h10 + 8'(b);
      do begin
        r = bus.tx_ready;
        @(posedge clk);
        #1 k++;
      end while (!r && k < 20000);
      chk("burst_accept_timeout", k < 20000, 1);
      acc[b] = cyc;
      if (b == 4) begin
        chk("burst_full_count", fifo_count, 4);
        chk("burst_full_ready", bus.tx_ready, 0);
        bus.tx_data = 8'hFF;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk);
          #1 chk("full_write_count", fifo_count, 4);
        end
      end
    end
    bus.tx_valid = 1'b0;
    chk("burst_first5", acc[4] - acc[0], 4);
    chk("burst_0x15", acc[5] - acc[1], 4342);
    wait_idle(30000);
    chk("burst_final_count", fifo_count, 0);
    chk("burst_rx_cnt", rx_q.size() - nrx, 6);
    if (rx_q.size() - nrx == 6)
      for (int b = 0; b < 6; b++) begin
        chk("burst_rx", rx_q[nrx+b], exp_burst[b]);
        if (b > 0) chk("burst_period", rx_t[nrx+b] - rx_t[nrx+b-1], 4341);
      end
    // Reset mid-frame during data bit 3 of 0x5A with two bytes queued
    send(8'h5A);
    send(8'h01);
    send(8'h02);
    repeat (4 * N + N / 2) @(posedge clk);
    #5 rst = 1'b0;
    #1 chk("midrst_tx", tx, 1);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_busy", tx_busy, 0);
    #100 rst = 1'b1;
    repeat (10 * N) @(posedge clk);
    nrx = rx_q.size();
    send(8'h3C);
    wait_idle(6000);
    chk("3c_ledg", LEDG, 8'h3C);
    chk("3c_rx_cnt", rx_q.size() - nrx, 1);
    if (rx_q.size() > nrx) chk("3c_rx", rx_q[$], 8'h3C);
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
